// File: rtl/calculation_unit_pkg.sv
// Shared definitions for the calculation unit datapath: default fraction
// width and the add/subtract operation encoding used by the fraction stages.
package calculation_unit_pkg;

   // Default fraction width including the hidden bit, format [x.xxx].
   localparam int FRAC_WIDTH_SP = 24;

   // Fraction operation selected by the in_sub input.
   typedef enum logic {
      FRAC_ADD = 1'b0,
      FRAC_SUB = 1'b1
   } frac_op_t;

endpackage : calculation_unit_pkg

// File: rtl/calculation_unit_leading_zero_counter.sv
// Combinational leading-zero counter: number of zero bits above the most
// significant set bit of value, and WIDTH when value is all zeros.
module calculation_unit_leading_zero_counter
   import calculation_unit_pkg::*;
#(
   parameter  int WIDTH     = 2 * FRAC_WIDTH_SP + 2,
   localparam int CNT_WIDTH = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0]     value,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 all_zero
);

   // Priority encode from the LSB upward so the highest set bit wins.
   always_comb begin
      // NOTE: every output gets a default before the loop, so no path leaves
      // it unassigned and no latch is inferred.
      count    = CNT_WIDTH'(WIDTH);
      all_zero = (value == '0);
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) begin
            count = CNT_WIDTH'(WIDTH - 1 - i);
         end
      end
   end

endmodule : calculation_unit_leading_zero_counter

// File: rtl/calculation_unit_fraction_addsub_pipe.sv
// Two-stage pipelined fraction add/subtract unit with valid/ready flow
// control. Stage 1 forms the raw signed sum/difference of the aligned
// fractions; stage 2 converts it to sign/magnitude and attaches the zero flag
// and leading-zero count consumed by the normaliser.
module calculation_unit_fraction_addsub_pipe
   import calculation_unit_pkg::*;
#(
   parameter  int FRAC_WIDTH = FRAC_WIDTH_SP,
   localparam int EXT_WIDTH  = 2 * FRAC_WIDTH + 1,
   localparam int LZC_WIDTH  = $clog2(EXT_WIDTH + 2)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sub,
   input  logic [FRAC_WIDTH-1:0] fraction_a,
   input  logic [EXT_WIDTH-1:0]  fraction_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXT_WIDTH:0]   result_magnitude,
   output logic                 result_negative,
   output logic                 result_zero,
   output logic [LZC_WIDTH-1:0] result_lzc
);

   // Magnitude is [xxx.xxx]; the raw result carries one extra sign bit.
   localparam int MAG_WIDTH = EXT_WIDTH + 1;
   localparam int RAW_WIDTH = EXT_WIDTH + 2;

   // Stage 1 combinational signals
   frac_op_t             op;
   logic [MAG_WIDTH-1:0] a_ext;
   logic [MAG_WIDTH-1:0] b_ext;
   logic [RAW_WIDTH-1:0] raw_next;
   logic                 borrow_next;

   // Stage 1 registers
   logic                 s1_valid;
   logic [RAW_WIDTH-1:0] s1_raw;
   logic                 s1_borrow;

   // Stage 2 combinational signals
   logic [MAG_WIDTH-1:0] mag_next;
   logic [LZC_WIDTH-1:0] lzc_next;
   logic                 zero_next;

   // Flow control
   logic                 s1_load;
   logic                 s2_load;

   // A stage may load when it is empty or its contents move on this cycle;
   // an empty s1 lets new data in even while s2 is stalled.
   assign s2_load  = !out_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;

   // Extend both operands onto the common [xxx.xxx] grid and add or subtract.
   always_comb begin
      op    = frac_op_t'(in_sub);
      a_ext = {2'b00, fraction_a, {FRAC_WIDTH{1'b0}}};
      b_ext = {1'b0, fraction_b};
      if (op == FRAC_SUB) begin
         raw_next = {1'b0, a_ext} - {1'b0, b_ext};
      end else begin
         raw_next = {1'b0, a_ext} + {1'b0, b_ext};
      end
      // An add of two non-negative values never sets the sign bit, so only a
      // subtraction can borrow.
      borrow_next = (op == FRAC_SUB) && raw_next[RAW_WIDTH-1];
   end

   // Stage 1 register: capture the raw result on an input handshake.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value of its inputs regardless of block order.
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_raw    <= '0;
         s1_borrow <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_raw    <= raw_next;
            s1_borrow <= borrow_next;
         end
      end
   end

   // Convert the raw result to magnitude; the negated value always fits in
   // MAG_WIDTH bits because a subtraction difference stays below 4.
   always_comb begin
      if (s1_borrow) begin
         mag_next = MAG_WIDTH'(-s1_raw);
      end else begin
         mag_next = s1_raw[MAG_WIDTH-1:0];
      end
   end

   // Leading-zero count and zero detect on the stage-2 magnitude.
   calculation_unit_leading_zero_counter #(
      .WIDTH (MAG_WIDTH)
   ) u_lzc (
      .value    (mag_next),
      .count    (lzc_next),
      .all_zero (zero_next)
   );

   // Stage 2 register: outputs come straight from here and hold while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid        <= 1'b0;
         result_magnitude <= '0;
         result_negative  <= 1'b0;
         result_zero      <= 1'b0;
         result_lzc       <= '0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result_magnitude <= mag_next;
            result_negative  <= s1_borrow;
            result_zero      <= zero_next;
            result_lzc       <= lzc_next;
         end
      end
   end

endmodule : calculation_unit_fraction_addsub_pipe

// File: tb/tb_calculation_unit_fraction_addsub_pipe.sv
// Self-checking bench for the pipelined fraction add/subtract unit. Expected
// results come from a plain-integer model of the fraction arithmetic; flow
// control is checked against pipeline occupancy.
module tb_calculation_unit_fraction_addsub_pipe;

   localparam int FW = 24;
   localparam int EW = 2 * FW + 1;
   localparam int MW = EW + 1;
   localparam int LW = $clog2(EW + 2);

   typedef struct {
      logic [MW-1:0] mag;
      logic          neg;
      logic          zero;
      logic [LW-1:0] lzc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic          in_sub;
   logic [FW-1:0] fraction_a;
   logic [EW-1:0] fraction_b;
   logic          out_valid;
   logic          out_ready;
   logic [MW-1:0] result_magnitude;
   logic          result_negative;
   logic          result_zero;
   logic [LW-1:0] result_lzc;

   int tests = 0;
   int fails = 0;

   calculation_unit_fraction_addsub_pipe dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_sub           (in_sub),
      .fraction_a       (fraction_a),
      .fraction_b       (fraction_b),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .result_magnitude (result_magnitude),
      .result_negative  (result_negative),
      .result_zero      (result_zero),
      .result_lzc       (result_lzc)
   );

   always #5 clk = ~clk;

   // Reference: a is scaled onto b's fractional grid, the signed result is
   // taken as an ordinary integer, lzc = MW minus the bit length of |result|.
   function automatic exp_t model(input bit sub, input logic [FW-1:0] fa,
                                  input logic [EW-1:0] fb);
      exp_t   r;
      longint av, bv, d, m;
      int     bl;
      av = longint'(fa) * (longint'(1) << FW);
      bv = longint'(fb);
      d  = sub ? av - bv : av + bv;
      r.neg  = (d < 0);
      m      = r.neg ? -d : d;
      r.mag  = m[MW-1:0];
      r.zero = (m == 0);
      bl = 0;
      while ((m >> bl) != 0) bl++;
      r.lzc = LW'(MW - bl);
      return r;
   endfunction

   function automatic exp_t observed();
      exp_t r;
      r.mag  = result_magnitude;
      r.neg  = result_negative;
      r.zero = result_zero;
      r.lzc  = result_lzc;
      return r;
   endfunction

   task automatic rand_operands();
      logic [FW-1:0] a;
      logic [EW-1:0] b;
      logic [EW-1:0] delta;
      a     = {1'b1, 23'($urandom)};
      delta = EW'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
         0:       b = {1'b0, a, {FW{1'b0}}};
         1:       b = {1'b0, a, {FW{1'b0}}} + delta;
         2:       b = EW'({$urandom, $urandom});
         default: b = EW'($urandom);
      endcase
      in_sub     = 1'($urandom_range(0, 1));
      fraction_a = a;
      fraction_b = b;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
      fraction_a = '0; fraction_b = '0;
      repeat (2) @(negedge clk);
      in_valid = 1'b1;  // ignored while reset is high
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
      tests++;
      if (result_magnitude !== '0 || result_negative !== 1'b0 || result_zero !== 1'b0 || result_lzc !== '0) begin
         fails++;
         $display("FAIL reset_outputs got mag=%h neg=%b zero=%b lzc=%0d expected all 0",
                  result_magnitude, result_negative, result_zero, result_lzc);
      end
      @(negedge clk); #1;
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_no_phantom got out_valid=%b expected 0", out_valid); end
   endtask

   task automatic run_vector(input string name, input bit sub, input logic [FW-1:0] a,
                             input logic [EW-1:0] b, input logic [MW-1:0] emag,
                             input bit eneg, input bit ezero, input logic [LW-1:0] elzc);
      @(negedge clk);
      in_valid = 1'b1; in_sub = sub; fraction_a = a; fraction_b = b; out_ready = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_in_ready got %b expected 1", name, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL %s_early got out_valid=%b expected 0 after 1 cycle", name, out_valid); end
      @(negedge clk); #1;
      tests++;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL %s_latency got out_valid=%b expected 1 after 2 cycles", name, out_valid); end
      tests++;
      if (result_magnitude !== emag || result_negative !== eneg || result_zero !== ezero || result_lzc !== elzc) begin
         fails++;
         $display("FAIL %s got mag=%h neg=%b zero=%b lzc=%0d expected mag=%h neg=%b zero=%b lzc=%0d",
                  name, result_magnitude, result_negative, result_zero, result_lzc,
                  emag, eneg, ezero, elzc);
      end
   endtask

   task automatic test_directed();
      exp_t m;
      run_vector("sub_equal", 1'b1, 24'h800000, 49'h0800000000000, 50'h0, 1'b0, 1'b1, 6'd50);
      run_vector("sub_half",  1'b1, 24'h800000, 49'h0400000000000, 50'h0400000000000, 1'b0, 1'b0, 6'd3);
      run_vector("sub_neg",   1'b1, 24'h800000, 49'h1000000000000, 50'h0800000000000, 1'b1, 1'b0, 6'd2);
      run_vector("add_4p5",   1'b0, 24'hC00000, 49'h1800000000000, 50'h2400000000000, 1'b0, 1'b0, 6'd0);
      // Largest possible add: all-ones operands.
      m = model(1'b0, '1, '1);
      run_vector("add_max", 1'b0, '1, '1, m.mag, m.neg, m.zero, m.lzc);
      // Smallest non-zero negative difference: b one LSB above a.
      run_vector("sub_lsb", 1'b1, 24'h800000, 49'h0800000000001, 50'h1, 1'b1, 1'b0, 6'd49);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [FW-1:0] va [4];
      logic [EW-1:0] vb [4];
      bit            vs [4];
      exp_t          ex [4];
      int            out_cyc [4];
      int            k, got;
      bit            saw_ready_low, prev_stall;
      exp_t          snap, o;
      for (int i = 0; i < 4; i++) begin
         rand_operands();
         va[i] = fraction_a; vb[i] = fraction_b; vs[i] = in_sub;
         ex[i] = model(vs[i], va[i], vb[i]);
         out_cyc[i] = -1;
      end
      k = 0; got = 0; saw_ready_low = 0; prev_stall = 0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 3 && cyc <= 8);
         if (k < 4) begin
            in_valid = 1'b1; in_sub = vs[k]; fraction_a = va[k]; fraction_b = vb[k];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         o = observed();
         if (prev_stall) begin
            tests++;
            if (out_valid !== 1'b1 || o !== snap) begin
               fails++;
               $display("FAIL b2b_hold cyc %0d got valid=%b mag=%h expected held mag=%h", cyc, out_valid, o.mag, snap.mag);
            end
         end
         if (in_valid && !in_ready) saw_ready_low = 1;
         if (out_valid && out_ready) begin
            tests++;
            if (o !== ex[got]) begin
               fails++;
               $display("FAIL b2b_result %0d got mag=%h neg=%b zero=%b lzc=%0d expected mag=%h neg=%b zero=%b lzc=%0d",
                        got, o.mag, o.neg, o.zero, o.lzc, ex[got].mag, ex[got].neg, ex[got].zero, ex[got].lzc);
            end
            out_cyc[got] = cyc;
            got++;
         end
         if (in_valid && in_ready) k++;
         prev_stall = out_valid && !out_ready;
         snap = o;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tests++;
      if (got != 4) begin fails++; $display("FAIL b2b_timeout got %0d results expected 4", got); end
      tests++;
      if (!saw_ready_low) begin fails++; $display("FAIL b2b_in_ready got never low expected low while both stages full"); end
      tests++;
      if (out_cyc[0] != 2 || out_cyc[1] != 9 || out_cyc[2] != 10 || out_cyc[3] != 11) begin
         fails++;
         $display("FAIL b2b_timing got cycles %0d %0d %0d %0d expected 2 9 10 11",
                  out_cyc[0], out_cyc[1], out_cyc[2], out_cyc[3]);
      end
      @(negedge clk);
   endtask

   task automatic test_random(input int n_in);
      exp_t q[$];
      exp_t snap, o, e;
      bit   prev_stall, exp_ready;
      int   issued, idle;
      issued = 0; prev_stall = 0; idle = 0;
      while ((issued < n_in || q.size() != 0) && idle < 50) begin
         @(negedge clk);
         if (issued < n_in) begin
            in_valid = ($urandom_range(0, 3) != 0);
            rand_operands();
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            in_valid = 1'b0;
            out_ready = 1'b1;
            idle++;
         end
         #1;
         o = observed();
         if (prev_stall) begin
            tests++;
            if (out_valid !== 1'b1 || o !== snap) begin
               fails++;
               $display("FAIL rand_hold got valid=%b mag=%h expected held mag=%h", out_valid, o.mag, snap.mag);
            end
         end
         exp_ready = !(q.size() == 2 && !out_ready);
         tests++;
         if (in_ready !== exp_ready) begin
            fails++;
            $display("FAIL rand_in_ready got %b expected %b (occupancy %0d)", in_ready, exp_ready, q.size());
         end
         if (out_valid && out_ready) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL rand_spurious got out_valid=1 expected no pending result");
            end else begin
               e = q.pop_front();
               if (o !== e) begin
                  fails++;
                  $display("FAIL rand_result got mag=%h neg=%b zero=%b lzc=%0d expected mag=%h neg=%b zero=%b lzc=%0d",
                           o.mag, o.neg, o.zero, o.lzc, e.mag, e.neg, e.zero, e.lzc);
               end
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(in_sub, fraction_a, fraction_b));
            issued++;
         end
         prev_stall = out_valid && !out_ready;
         snap = o;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tests++;
      if (q.size() != 0) begin fails++; $display("FAIL rand_drain got %0d results outstanding expected 0", q.size()); end
   endtask

   task automatic test_reset_mid();
      // Park a non-zero result in s2 so the reset must clear visible outputs.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_sub = 1'b0;
      fraction_a = 24'hC00000; fraction_b = 49'h1800000000000;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      // Second operand set accepted into s1 while s2 is stalled.
      in_valid = 1'b1; in_sub = 1'b1; fraction_a = 24'h800000; fraction_b = 49'h0400000000000;
      @(negedge clk);
      reset = 1'b1;  // in_valid still high: must be ignored
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_out_valid got %b expected 0", out_valid); end
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_in_ready got %b expected 1", in_ready); end
      tests++;
      if (result_magnitude !== '0 || result_negative !== 1'b0 || result_zero !== 1'b0 || result_lzc !== '0) begin
         fails++;
         $display("FAIL mid_reset_outputs got mag=%h neg=%b zero=%b lzc=%0d expected all 0",
                  result_magnitude, result_negative, result_zero, result_lzc);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         tests++;
         if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_discard cyc %0d got out_valid=%b expected 0", i, out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random(400);
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_calculation_unit_fraction_addsub_pipe
